mem_lut_search: RTL
===================

MEM_LUT_SEARCH -- requirements
Module: mem_lut_search

Interface
REQ-001 SHALL have parameter ENTRIES, default 32, number of table entries.
REQ-002 SHALL have parameter AW, default 5, index width (log2 ENTRIES).
REQ-003 SHALL have parameter DW, default 8, entry/key data width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port wr_en  input  1  write one table entry this cycle.
REQ-007 SHALL have port wr_addr  input  AW  entry index to write.
REQ-008 SHALL have port wr_data  input  DW  value to store; entry marked valid.
REQ-009 SHALL have port clr_all  input  1  invalidate all entries this cycle.
REQ-010 SHALL have port req_valid  input  1  search request present.
REQ-011 SHALL have port req_key  input  DW  value to search for.
REQ-012 SHALL have port req_ready  output  1  block can accept a request.
REQ-013 SHALL have port rsp_valid  output  1  search result present.
REQ-014 SHALL have port rsp_hit  output  1  1 = key found, 0 = miss.
REQ-015 SHALL have port rsp_index  output  AW  lowest matching index; 0 on miss.
REQ-016 SHALL have port rsp_ready  input  1  consumer accepts result.

Function
REQ-017 SHALL hold ENTRIES x DW storage plus one valid bit per entry; search is the inverse of indexed read: value in, index out.
REQ-018 SHALL implement FSM IDLE, SEARCH, DONE; req_ready = 1 only in IDLE, rsp_valid = 1 only in DONE.
REQ-019 SHALL accept a request on an edge with req_valid & req_ready: latch req_key, clear scan counter to 0, go to SEARCH.
REQ-020 SHALL in SEARCH compare exactly one entry per cycle, entry[counter], match = valid & (data == latched key).
REQ-021 SHALL on match go to DONE with rsp_hit=1, rsp_index=counter; lowest matching index wins.
REQ-022 SHALL on no match at counter = ENTRIES-1 go to DONE with rsp_hit=0, rsp_index=0; otherwise increment counter.
REQ-023 SHALL give latency: accept edge E0, hit at index k -> rsp_valid high after edge E0+k+1; miss -> after edge E0+ENTRIES.
REQ-024 SHALL hold rsp_valid, rsp_hit, rsp_index stable in DONE until rsp_ready=1, then return to IDLE on that edge; new request accepted no earlier than the following edge.
REQ-025 SHALL accept writes and clr_all in any state; update visible from next cycle; compare in same cycle uses old contents.
REQ-026 SHALL NOT rescan entries already passed if rewritten mid-search.
REQ-027 SHALL give clr_all priority over wr_en in the same cycle (all entries invalid, write dropped).
REQ-028 SHALL ignore req_valid outside IDLE; req_key changes after accept have no effect.
REQ-029 SHALL treat rsp_ready outside DONE as don't-care.

Reset
REQ-030 SHALL on rst_n=0, immediately and asynchronously: state IDLE, all valid bits 0, counter 0, req_ready=1, rsp_valid=0, rsp_hit=0, rsp_index=0.
REQ-031 SHALL abort any in-progress search or pending response on reset; no response is produced for it.
REQ-032 SHALL leave entry data contents unspecified after reset; only valid bits are defined.

Verification
REQ-033 SHALL pass: load entries 0..12 with 60..72, search key 66 -> rsp_hit=1, rsp_index=6, rsp_valid 7 edges after accept.
REQ-034 SHALL pass: same table, search key 99 -> rsp_hit=0, rsp_index=0, rsp_valid 32 edges after accept.
REQ-035 SHALL pass: write 72 also to entry 20, search 72 -> rsp_index=12; then clr_all, search 72 -> miss.
REQ-036 SHALL pass: hold rsp_ready=0 for 5 cycles in DONE -> outputs stable, req_ready=0, second req_valid ignored; rsp_ready=1 -> IDLE next edge.
REQ-037 SHALL pass: during search of key 80, write 80 to entry 3 when counter=10 -> miss; write 80 to entry 25 at same point -> hit index 25.
REQ-038 SHALL pass: assert rst_n=0 mid-SEARCH (counter=15) -> outputs at reset values without a clock edge; subsequent search of 60 -> miss.

Source files
------------

// File: rtl/mem_lut_search.sv
`default_nettype none
// ============================================================================
//  Module   : mem_lut_search
//  Purpose  : Small lookup table searched by value. Entries are written by
//             index; a search request supplies a key and the block returns the
//             lowest valid index whose stored value equals that key. The scan
//             examines one entry per clock.
//  Ports    : clk, rst_n                     - clock, async active-low reset
//             wr_en, wr_addr, wr_data        - single-entry table write
//             clr_all                        - invalidate every entry
//             req_valid, req_key, req_ready  - search request handshake
//             rsp_valid, rsp_hit, rsp_index,
//             rsp_ready                      - search response handshake
//  Revision : 1.0 - initial release
// ============================================================================
module mem_lut_search #(
    parameter int ENTRIES = 32,
    parameter int AW      = 5,
    parameter int DW      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          clr_all,
    input  logic          req_valid,
    input  logic [DW-1:0] req_key,
    output logic          req_ready,
    output logic          rsp_valid,
    output logic          rsp_hit,
    output logic [AW-1:0] rsp_index,
    input  logic          rsp_ready
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [AW-1:0] c_last = AW'(ENTRIES - 1);

    logic [DW-1:0]      r_data [ENTRIES];
    logic [ENTRIES-1:0] r_valid;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [AW-1:0]      r_cnt;
    logic [DW-1:0]      r_key;
    logic               r_hit;
    logic [AW-1:0]      r_index;
    logic               w_match;
    logic               w_last;

    // Entry contents are deliberately not reset; only the valid bits define
    // whether an entry can match. A clear in the same cycle drops the write.
    always_ff @(posedge clk) begin
        if (wr_en && !clr_all) begin
            r_data[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (clr_all) begin
            r_valid <= '0;
        end else if (wr_en) begin
            r_valid[wr_addr] <= 1'b1;
        end
    end

    // Compare reads the registered table, so a write landing on the same
    // edge is only seen by later compares. Entries already passed are never
    // revisited, so a late write behind the counter cannot produce a hit.
    assign w_match = r_valid[r_cnt] && (r_data[r_cnt] == r_key);
    assign w_last  = (r_cnt == c_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (w_match || w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_key   <= '0;
            r_hit   <= 1'b0;
            r_index <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_key <= req_key;
                        r_cnt <= '0;
                    end
                end
                S_SEARCH: begin
                    if (w_match) begin
                        r_hit   <= 1'b1;
                        r_index <= r_cnt;
                    end else if (w_last) begin
                        r_hit   <= 1'b0;
                        r_index <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_DONE);
    assign rsp_hit   = r_hit;
    assign rsp_index = r_index;

endmodule
`default_nettype wire
